// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the CPU and a DMA master, with programmable wait states
// and a turnaround cycle. Define MEM_BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: CPU priority).
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] cpu_a,
  input  logic        cpu_n_oe,
  input  logic        cpu_n_we,
  output logic        cpu_n_rdy,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_a,
  output logic        dma_ack,
  output logic [15:0] mem_a,
  output logic        mem_n_oe,
  output logic        mem_n_we,
  output logic        n_cpu_d_oe,
  output logic        n_dma_d_oe
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);
  localparam logic       ZERO_WS  = (LAST_CNT == 3'd0);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, TURN} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] cnt_inc;
  logic       cpu_req;
  logic       cpu_wr;
  logic       any_req;
  logic       grant_dma;
  logic       grant_wr;
  logic       last_beat;

  // Simultaneous OE and WE from the CPU is illegal and resolves to a read.
  assign cpu_req = ~cpu_n_oe | ~cpu_n_we;
  assign cpu_wr  = cpu_n_oe & ~cpu_n_we;
  assign any_req = cpu_req | dma_req;
  assign cnt_inc = cnt + 3'd1;
  assign last_beat = (cnt_inc == LAST_CNT);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  logic last_dma;

  // On contention, hand the bus to whichever master was not served last.
  assign grant_dma = dma_req & (~cpu_req | ~last_dma);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      last_dma <= 1'b1;
    else if (state == IDLE && any_req)
      last_dma <= grant_dma;
  end
`else
  assign grant_dma = dma_req & ~cpu_req;
`endif

  assign grant_wr = grant_dma ? dma_we : cpu_wr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      mem_a      <= 16'h0000;
      mem_n_oe   <= 1'b1;
      mem_n_we   <= 1'b1;
      n_cpu_d_oe <= 1'b1;
      n_dma_d_oe <= 1'b1;
      cpu_n_rdy  <= 1'b1;
      dma_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= grant_dma ? DMA_ACC : CPU_ACC;
            cnt        <= 3'd0;
            mem_a      <= grant_dma ? dma_a : cpu_a;
            mem_n_oe   <= grant_wr;
            mem_n_we   <= ~grant_wr;
            n_cpu_d_oe <= grant_dma;
            n_dma_d_oe <= ~grant_dma;
            // With zero wait states the first strobe cycle is also the completion cycle.
            cpu_n_rdy  <= ~(~grant_dma & ZERO_WS);
            dma_ack    <= grant_dma & ZERO_WS;
          end
        end

        CPU_ACC, DMA_ACC: begin
          if (cnt == LAST_CNT) begin
            state      <= TURN;
            cnt        <= 3'd0;
            mem_n_oe   <= 1'b1;
            mem_n_we   <= 1'b1;
            n_cpu_d_oe <= 1'b1;
            n_dma_d_oe <= 1'b1;
            cpu_n_rdy  <= 1'b1;
            dma_ack    <= 1'b0;
          end else begin
            cnt       <= cnt_inc;
            cpu_n_rdy <= ~((state == CPU_ACC) & last_beat);
            dma_ack   <= (state == DMA_ACC) & last_beat;
          end
        end

        TURN: begin
          state      <= IDLE;
          mem_n_oe   <= 1'b1;
          mem_n_we   <= 1'b1;
          n_cpu_d_oe <= 1'b1;
          n_dma_d_oe <= 1'b1;
          cpu_n_rdy  <= 1'b1;
          dma_ack    <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
